// File: rtl/mul_seq_pkg.sv
// Shared types for the mul_seq sequential shift-add multiplier.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle for mul_seq; sgn exists only with MUL_SEQ_SIGNED_EN.
interface mul_seq_if #(parameter int W = 8);
  logic           start;
`ifdef MUL_SEQ_SIGNED_EN
  logic           sgn;
`endif
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;

`ifdef MUL_SEQ_SIGNED_EN
  modport master (output start, sgn, a, b, input busy, done, y);
  modport slave  (input start, sgn, a, b, output busy, done, y);
`else
  modport master (output start, a, b, input busy, done, y);
  modport slave  (input start, a, b, output busy, done, y);
`endif
endinterface

// File: rtl/mul_seq_dp.sv
// Datapath for mul_seq: operand/accumulator registers and the shift-add step.
// Sign-magnitude handling is compiled in with MUL_SEQ_SIGNED_EN.
module mul_seq_dp #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           finish,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic           sgn,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           rb_last,
  output logic [2*W-1:0] y
);

  logic [2*W-1:0] ra;
  logic [W-1:0]   rb;
  logic [2*W-1:0] ry;
  logic [2*W-1:0] sum;
  logic [W-1:0]   amag;
  logic [W-1:0]   bmag;
  logic           neg_sel;

`ifdef MUL_SEQ_SIGNED_EN
  logic neg;

  // -2^(W-1) negates to itself, which read unsigned is exactly its magnitude
  assign amag    = (sgn && a[W-1]) ? -a : a;
  assign bmag    = (sgn && b[W-1]) ? -b : b;
  assign neg_sel = neg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      neg <= 1'b0;
    else if (load) neg <= sgn & (a[W-1] ^ b[W-1]);
  end
`else
  assign amag    = a;
  assign bmag    = b;
  assign neg_sel = 1'b0;
`endif

  assign sum     = rb[0] ? ry + ra : ry;
  assign rb_last = (rb[W-1:1] == '0);
  assign y       = ry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra <= '0;
      rb <= '0;
      ry <= '0;
    end else if (load) begin
      ra <= {{W{1'b0}}, amag};
      rb <= bmag;
      ry <= '0;
    end else if (step) begin
      ra <= ra << 1;
      rb <= rb >> 1;
      ry <= (finish && neg_sel) ? -sum : sum;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier with start/busy/done handshake.
// Two's-complement mode is enabled by defining MUL_SEQ_SIGNED_EN.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic    clk,
  input  logic    rst,
  mul_seq_if.slave bus
);

  state_t state;
  state_t nxt;
  logic   load;
  logic   step;
  logic   finish;
  logic   rb_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // The shift that empties rb is the final step, so finish coincides with it
  always_comb begin
    nxt    = state;
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load = 1'b1;
          nxt  = (bus.b == '0) ? DONE : RUN;
        end else begin
          nxt  = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (rb_last) begin
          finish = 1'b1;
          nxt    = DONE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  mul_seq_dp #(.W(W)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .finish  (finish),
`ifdef MUL_SEQ_SIGNED_EN
    .sgn     (bus.sgn),
`endif
    .a       (bus.a),
    .b       (bus.b),
    .rb_last (rb_last),
    .y       (bus.y)
  );

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq (W=4; W=8 signed sweep when MUL_SEQ_SIGNED_EN).
module tb_mul_seq;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned failures;

  mul_seq_if #(.W(4)) bus4 ();
  mul_seq #(.W(4)) dut (.clk(clk), .rst(rst), .bus(bus4));

`ifdef MUL_SEQ_SIGNED_EN
  mul_seq_if #(.W(8)) bus8 ();
  mul_seq #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and measures acceptance-to-done latency (accepting edge = 1)
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output int unsigned edges, output int unsigned busy_cyc);
    bus4.a     = a;
    bus4.b     = b;
`ifdef MUL_SEQ_SIGNED_EN
    bus4.sgn   = s;
`else
    if (s) $display("note: sgn ignored in unsigned build");
`endif
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    edges    = 1;
    busy_cyc = 0;
    while (!bus4.done && edges < 20) begin
      if (bus4.busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
`ifdef MUL_SEQ_SIGNED_EN
    bus4.sgn = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sgn = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.y !== 8'h00) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b y=%h, required 0 0 00", bus4.busy, bus4.done, bus4.y);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int unsigned e, bc;
    run_op(4'd13, 4'd11, 1'b0, e, bc);
    checks++;
    if (bus4.y !== 8'h8F || e !== 5 || bc !== 4) begin
      failures++;
      $display("FAIL basic_13x11: y=%h edges=%0d busy=%0d, required 8f 5 4", bus4.y, e, bc);
    end
    @(posedge clk); #1;
    checks++;
    if (bus4.done !== 1'b0 || bus4.y !== 8'h8F) begin
      failures++;
      $display("FAIL done_pulse: done=%b y=%h, required 0 8f", bus4.done, bus4.y);
    end
  endtask

  task automatic test_zero();
    int unsigned e, bc;
    run_op(4'd7, 4'd0, 1'b0, e, bc);
    checks++;
    if (bus4.y !== 8'h00 || e !== 1 || bc !== 0) begin
      failures++;
      $display("FAIL zero_b: y=%h edges=%0d busy=%0d, required 00 1 0", bus4.y, e, bc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int unsigned e, bc;
    run_op(4'd15, 4'd1, 1'b0, e, bc);
    checks++;
    if (bus4.y !== 8'h0F || e !== 2 || bc !== 1) begin
      failures++;
      $display("FAIL b2b_first: y=%h edges=%0d busy=%0d, required 0f 2 1", bus4.y, e, bc);
    end
    // still in the done cycle: request is accepted immediately
    run_op(4'd15, 4'd15, 1'b0, e, bc);
    checks++;
    if (bus4.y !== 8'hE1 || e !== 5 || bc !== 4) begin
      failures++;
      $display("FAIL b2b_second: y=%h edges=%0d busy=%0d, required e1 5 4", bus4.y, e, bc);
    end
    bus4.a = 4'd3; bus4.b = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus4.y !== 8'hE1 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: y=%h busy=%b done=%b, required e1 0 0", bus4.y, bus4.busy, bus4.done);
    end
  endtask

  task automatic test_ignore_start();
    int unsigned e;
    bus4.a = 4'd13; bus4.b = 4'd11; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    bus4.a = 4'd3; bus4.b = 4'd3; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    e = 3;
    while (!bus4.done && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    checks++;
    if (bus4.y !== 8'h8F || e !== 5) begin
      failures++;
      $display("FAIL ignore_start: y=%h edges=%0d, required 8f 5", bus4.y, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int unsigned e, bc;
    bus4.a = 4'd9; bus4.b = 4'd14; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.y !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_run: busy=%b done=%b y=%h, required 0 0 00", bus4.busy, bus4.done, bus4.y);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle: busy=%b done=%b, required 0 0", bus4.busy, bus4.done);
    end
    run_op(4'd9, 4'd14, 1'b0, e, bc);
    checks++;
    if (bus4.y !== 8'h7E || e !== 5 || bc !== 4) begin
      failures++;
      $display("FAIL after_rst: y=%h edges=%0d busy=%0d, required 7e 5 4", bus4.y, e, bc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_msb();
    int unsigned e, bc;
    run_op(4'hD, 4'd5, 1'b0, e, bc);
    checks++;
    if (bus4.y !== 8'h41 || e !== 4 || bc !== 3) begin
      failures++;
      $display("FAIL unsigned_13x5: y=%h edges=%0d busy=%0d, required 41 4 3", bus4.y, e, bc);
    end
    @(posedge clk); #1;
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed();
    int unsigned e, bc;
    run_op(4'hD, 4'd5, 1'b1, e, bc);
    checks++;
    if (bus4.y !== 8'hF1 || e !== 4 || bc !== 3) begin
      failures++;
      $display("FAIL signed_m3x5: y=%h edges=%0d busy=%0d, required f1 4 3", bus4.y, e, bc);
    end
    run_op(4'h8, 4'h8, 1'b1, e, bc);
    checks++;
    if (bus4.y !== 8'h40 || e !== 5 || bc !== 4) begin
      failures++;
      $display("FAIL signed_m8xm8: y=%h edges=%0d busy=%0d, required 40 5 4", bus4.y, e, bc);
    end
    run_op(4'd3, 4'hF, 1'b1, e, bc);
    checks++;
    if (bus4.y !== 8'hFD || e !== 2 || bc !== 1) begin
      failures++;
      $display("FAIL signed_3xm1: y=%h edges=%0d busy=%0d, required fd 2 1", bus4.y, e, bc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_sweep8();
    logic [7:0]         a, b;
    logic               s;
    logic signed [15:0] exp_s;
    logic [15:0]        exp;
    int unsigned        e;
    for (int unsigned i = 0; i < 60; i++) begin
      case (i)
        0:       begin a = 8'h80; b = 8'h80; s = 1'b1; end
        1:       begin a = 8'h80; b = 8'h7F; s = 1'b1; end
        2:       begin a = 8'hFF; b = 8'hFF; s = 1'b0; end
        3:       begin a = 8'h05; b = 8'h00; s = 1'b1; end
        default: begin
          a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
        end
      endcase
      if (s) begin
        exp_s = $signed(a) * $signed(b);
        exp   = exp_s;
      end else begin
        exp = {8'h00, a} * {8'h00, b};
      end
      bus8.a = a; bus8.b = b; bus8.sgn = s; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      e = 1;
      while (!bus8.done && e < 20) begin
        @(posedge clk); #1;
        e++;
      end
      checks++;
      if (bus8.y !== exp || bus8.done !== 1'b1) begin
        failures++;
        $display("FAIL sweep8 a=%h b=%h sgn=%b: y=%h done=%b, required %h 1", a, b, s, bus8.y, bus8.done, exp);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_unsigned_msb();
`ifdef MUL_SEQ_SIGNED_EN
    test_signed();
    test_signed_sweep8();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised sequential shift-add multiplier with a start/busy/done handshake. It is the successor to the fixed 4-bit load-driven multiplier, with configurable operand width, early termination on an exhausted multiplier and optional two's-complement mode. It sits as a multi-cycle arithmetic unit behind a simple controller that issues one product request at a time.

## Interface
- W, 8, operand width in bits (W ≥ 2); the product is 2W bits.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- sgn  in  1  operands are two's complement when 1 (present only with MUL_SEQ_SIGNED_EN).
- a  in  W  multiplicand, sampled on the accepting edge.
- b  in  W  multiplier, sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse, high while in DONE.
- y  out  2W  product register; valid while done is high, held until the next accepted start.

## Operation
- Internal registers: ra (2W, multiplicand, shifts left), rb (W, multiplier, shifts right), ry (2W, accumulator, drives y), neg (1, signed mode only).
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1: load ra={W'0, |a|}, rb=|b|, ry=0. Next state is RUN, or DONE directly if b==0.
- IDLE or DONE with start=0: next state is IDLE.
- RUN step, every cycle:
  - if rb[0]: ry ← ry + ra;
  - ra ← ra<<1; rb ← rb>>1.
  - If the shifted rb is 0, next state is DONE; otherwise stay in RUN.
- Early termination: the number of RUN cycles is n = index of the highest set bit of |b| + 1 (1 ≤ n ≤ W).
- Unsigned arithmetic: the 2W-bit accumulator cannot overflow; no truncation occurs.
- start while busy is ignored. a, b and sgn may change freely after acceptance.
- Reset, at any time including mid-RUN: state=IDLE, ra=rb=ry=0, neg=0, busy=0, done=0, y=0. The in-flight operation is discarded.

## Timing
- Latency from the accepting edge to done high is n+1 edges (maximum W+1); for b==0 it is 1 edge.
- busy is high for exactly n cycles; for b==0 busy is never asserted.
- done is high for exactly one cycle. A start in that cycle is accepted (back-to-back operation), giving zero idle gap.
- y changes during RUN and is meaningful only from the DONE cycle onward. It is stable in IDLE.
- Outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Configuration
- MUL_SEQ_SIGNED_EN defined:
  - The sgn port exists.
  - With sgn=1 on acceptance: magnitudes |a| and |b| are loaded, and neg = a[W-1]^b[W-1].
  - On the edge entering DONE, the final step's result is two's-complement negated when neg=1.
  - -2^(W-1) is handled: its magnitude fits in W unsigned bits.
  - With sgn=0, behaviour is identical to unsigned.
- MUL_SEQ_SIGNED_EN undefined: the sgn port and neg register are absent, and operands are always unsigned.

## Structure
- Package mul_seq_pkg: the state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module mul_seq_dp holds ra/rb/ry, the shift-add step and the optional sign handling, controlled by load/step/finish strobes.
- mul_seq holds the FSM and the handshake outputs.

## Test plan
All scenarios use W=4 unless noted.
- a=13, b=11, start pulse → busy high 4 cycles, done on the 5th edge, y=143 (8'h8F).
- a=7, b=0 → busy never high, done 1 edge after acceptance, y=0.
- a=15, b=1 → busy 1 cycle, done on the 2nd edge, y=15. Then start in the done cycle with a=15, b=15 → accepted, y=225 four RUN cycles later.
- start re-pulsed with different operands during RUN → ignored; the original product is returned.
- rst asserted mid-RUN (a=9, b=14) → busy, done and y go to 0 immediately, state returns to IDLE, and the next start computes correctly.
- MUL_SEQ_SIGNED_EN, sgn=1:
  - a=4'hD (-3), b=5 → y=8'hF1 (-15);
  - a=4'h8, b=4'h8 (-8×-8) → y=8'h40;
  - W=8 random sweep against a reference model.
